// File: rtl/signal_counter.sv
`default_nettype none
// ============================================================================
// Module   : signal_counter
// Brief    : Saturating cycle counter; signal asserts once THRESHOLD is hit.
// Revision : 1.0 - initial release
// ============================================================================
module signal_counter #(
    parameter int WIDTH     = 5,
    parameter int THRESHOLD = 20
) (
    input  logic clk,
    input  logic areset,
    input  logic reset,
    output logic signal
);

    localparam logic [WIDTH-1:0] C_THRESHOLD = WIDTH'(THRESHOLD);

    logic [WIDTH-1:0] count;
    logic             w_at_threshold;

    assign w_at_threshold = (count == C_THRESHOLD);

    // Holding at THRESHOLD keeps count from ever passing it or wrapping.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            count <= '0;
        end else if (reset) begin
            count <= '0;
        end else if (!w_at_threshold) begin
            count <= count + 1'b1;
        end
    end

    assign signal = w_at_threshold;

endmodule
`default_nettype wire

// File: tb/tb_signal_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_signal_counter
// Brief    : Table-driven, directed and randomized checks of signal_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signal_counter;

    localparam int C_WIDTH     = 5;
    localparam int C_THRESHOLD = 20;

    logic clk;
    logic areset;
    logic reset;
    logic signal;

    int checks   = 0;
    int failures = 0;
    int m_count  = 0;

    typedef struct {
        logic ar;
        logic rs;
        int   cnt;
        logic sig;
    } vec_t;

    vec_t vt[31];

    signal_counter #(
        .WIDTH    (C_WIDTH),
        .THRESHOLD(C_THRESHOLD)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .reset (reset),
        .signal(signal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d exp=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: reset wins, otherwise count up and stop at the threshold.
    task automatic tick();
        @(posedge clk);
        if (!areset)                  m_count = 0;
        else if (reset)               m_count = 0;
        else if (m_count < C_THRESHOLD) m_count = m_count + 1;
        #1;
    endtask

    task automatic chk_model(input string name);
        chk({name, "_count"},  int'(dut.count), m_count);
        chk({name, "_signal"}, int'(signal),    (m_count == C_THRESHOLD) ? 1 : 0);
    endtask

    initial begin
        // Table: one reset edge, 20 edges up to saturation, 10 more holding.
        vt[0] = '{ar: 1'b1, rs: 1'b1, cnt: 0, sig: 1'b0};
        for (int i = 1; i <= 20; i++)
            vt[i] = '{ar: 1'b1, rs: 1'b0, cnt: i, sig: (i == C_THRESHOLD)};
        for (int i = 21; i <= 30; i++)
            vt[i] = '{ar: 1'b1, rs: 1'b0, cnt: C_THRESHOLD, sig: 1'b1};

        areset = 1'b0;
        reset  = 1'b0;
        #2;
        chk("async_reset_no_edge_count",  int'(dut.count), 0);
        chk("async_reset_no_edge_signal", int'(signal),    0);
        m_count = 0;

        for (int i = 0; i < 31; i++) begin
            areset = vt[i].ar;
            reset  = vt[i].rs;
            tick();
            chk($sformatf("table%0d_count", i),  int'(dut.count), vt[i].cnt);
            chk($sformatf("table%0d_signal", i), int'(signal),    int'(vt[i].sig));
        end

        // Sync reset pulse mid-count at 12.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("reach12_count", int'(dut.count), 12);
        reset = 1'b1;
        tick();
        chk("sync_clr_count",  int'(dut.count), 0);
        chk("sync_clr_signal", int'(signal),    0);
        reset = 1'b0;
        tick();
        chk("resume_count", int'(dut.count), 1);

        // Held sync reset keeps everything at zero.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_reset_count",  int'(dut.count), 0);
            chk("held_reset_signal", int'(signal),    0);
        end
        reset = 1'b0;

        // Saturate, then async reset between edges together with reset=1.
        for (int i = 0; i < 25; i++) tick();
        chk("resat_signal", int'(signal), 1);
        #2;
        areset = 1'b0;
        reset  = 1'b1;
        #1;
        m_count = 0;
        chk("async_mid_count",  int'(dut.count), 0);
        chk("async_mid_signal", int'(signal),    0);
        tick();
        chk("async_held_count", int'(dut.count), 0);
        areset = 1'b1;
        reset  = 1'b0;
        tick();
        chk("after_async_count", int'(dut.count), 1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            areset = ($urandom_range(0, 29) != 0);
            reset  = ($urandom_range(0, 39) == 0);
            tick();
            chk_model("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                areset = 1'b0;
                #1;
                m_count = 0;
                chk_model("rand_async");
                areset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
